// File: rtl/blackparrot_chip_pkg.sv
// Chip-level defaults for the BlackParrot DRAM bridge fan-out.
package blackparrot_chip_pkg;
   localparam int bp_dram_channels_gp        = 2;
   localparam int bp_dram_max_outstanding_gp = 8;
   localparam int bp_dram_hash_lsb_gp        = 6;

   function automatic int bp_dram_order_els(input int channels, input int max_outstanding);
      return channels * max_outstanding;
   endfunction
endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-array FIFO, one read and one write port; data_o is valid the cycle after push.
// Backpressure: ready_o drops when full; yumi_i pops the head when v_o is high.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 1,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);
   localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w = $clog2(els_p + 1);

   logic [width_p-1:0] mem [els_p];
   logic [ptr_w-1:0]   rptr, wptr;
   logic [cnt_w-1:0]   cnt;
   logic               push, pop;

   // Pointers wrap explicitly so els_p need not be a power of two.
   function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign ready_o = (cnt != cnt_w'(els_p));
   assign v_o     = (cnt != '0);
   assign data_o  = mem[rptr];
   assign push    = v_i & ready_o;
   assign pop     = yumi_i & v_o;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= nxt(wptr);
         if (pop)  rptr <= nxt(rptr);
         if (push & ~pop)      cnt <= cnt + 1'b1;
         else if (pop & ~push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= data_i;
   end
endmodule

// File: rtl/bsg_blackparrot_dram_scheduler.sv
// Address-hashed fan-out of mem commands to DRAM channels with in-order response return.
// Command path is 0 cycles; per-channel credit limit plus order-queue depth stall cmd_ready_and_o.
module bsg_blackparrot_dram_scheduler
   import blackparrot_chip_pkg::*;
#(
   parameter int channels_p        = bp_dram_channels_gp,
   parameter int max_outstanding_p = bp_dram_max_outstanding_gp,
   parameter int msg_width_p       = 128,
   parameter int paddr_width_p     = 40,
   parameter int hash_lsb_p        = bp_dram_hash_lsb_gp
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [msg_width_p-1:0]                 cmd_i,
   input  logic [paddr_width_p-1:0]               cmd_addr_i,
   input  logic                                   cmd_v_i,
   output logic                                   cmd_ready_and_o,
   output logic [msg_width_p-1:0]                 resp_o,
   output logic                                   resp_v_o,
   input  logic                                   resp_yumi_i,
   output logic [channels_p-1:0][msg_width_p-1:0] chan_cmd_o,
   output logic [channels_p-1:0]                  chan_cmd_v_o,
   input  logic [channels_p-1:0]                  chan_cmd_ready_and_i,
   input  logic [channels_p-1:0][msg_width_p-1:0] chan_resp_i,
   input  logic [channels_p-1:0]                  chan_resp_v_i,
   output logic [channels_p-1:0]                  chan_resp_yumi_o,
   output logic                                   idle_o,
   output logic                                   protocol_err_o
);
   localparam int lg_ch     = $clog2(channels_p);
   localparam int cnt_w     = $clog2(max_outstanding_p + 1);
   localparam int order_els = bp_dram_order_els(channels_p, max_outstanding_p);

   logic [lg_ch-1:0]                 target, head;
   logic [channels_p-1:0][cnt_w-1:0] count_r;
   logic [channels_p-1:0]            inc, dec, unsolicited;
   logic                             room, queue_ready, queue_v, accept, pop;
   logic                             unused_addr;

   assign unused_addr = ^cmd_addr_i;
   assign target      = cmd_addr_i[hash_lsb_p +: lg_ch];

   assign room            = queue_ready & (count_r[target] < cnt_w'(max_outstanding_p));
   assign cmd_ready_and_o = ~reset_i & room & chan_cmd_ready_and_i[target];
   assign accept          = cmd_v_i & cmd_ready_and_o;

   assign resp_v_o = ~reset_i & queue_v & chan_resp_v_i[head];
   assign resp_o   = chan_resp_i[head];
   assign pop      = resp_yumi_i & resp_v_o;
   assign idle_o   = reset_i | ~queue_v;

   always_comb begin
      chan_cmd_v_o     = '0;
      chan_resp_yumi_o = '0;
      inc              = '0;
      dec              = '0;
      unsolicited      = '0;
      chan_cmd_v_o[target] = cmd_v_i & room & ~reset_i;
      chan_resp_yumi_o[head] = pop;
      inc[target] = accept;
      dec[head]   = pop;
      for (int k = 0; k < channels_p; k++) begin
         chan_cmd_o[k]  = cmd_i;
         unsolicited[k] = chan_resp_v_i[k] & (count_r[k] == '0);
      end
   end

   // Holds the channel ID of every accepted command, oldest at the head.
   bsg_fifo_1r1w_small #(
      .width_p (lg_ch),
      .els_p   (order_els)
   ) order_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (accept),
      .ready_o (queue_ready),
      .data_i  (target),
      .v_o     (queue_v),
      .data_o  (head),
      .yumi_i  (pop)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_r        <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         for (int k = 0; k < channels_p; k++) begin
            if (inc[k] & ~dec[k])      count_r[k] <= count_r[k] + 1'b1;
            else if (dec[k] & ~inc[k]) count_r[k] <= count_r[k] - 1'b1;
         end
         protocol_err_o <= protocol_err_o | (|unsolicited);
      end
   end
endmodule

// File: tb/tb_bsg_blackparrot_dram_scheduler.sv
// Bench for the DRAM scheduler: queue-based reference model checked every cycle plus directed scenarios.
module tb_bsg_blackparrot_dram_scheduler;
   localparam int CH  = 2;
   localparam int MAX = 8;
   localparam int MW  = 128;
   localparam int AW  = 40;
   localparam int LSB = 6;
   localparam logic [MW-1:0] K  = {4{32'hA5C3_0F96}};
   localparam logic [MW-1:0] M0 = {4{32'h1111_0000}};
   localparam logic [MW-1:0] M1 = {4{32'h2222_0001}};
   localparam logic [MW-1:0] R0 = {4{32'hCAFE_0000}};
   localparam logic [MW-1:0] R1 = {4{32'hBEEF_0001}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, cmd_v, cmd_ready, resp_v, yumi, idle, perr;
   logic [AW-1:0]          cmd_addr;
   logic [MW-1:0]          cmd_msg, resp_d;
   logic [CH-1:0][MW-1:0]  chan_cmd_d, crd;
   logic [CH-1:0]          chan_cmd_v, chan_rdy, crv, cy;

   bsg_blackparrot_dram_scheduler #(
      .channels_p(CH), .max_outstanding_p(MAX), .msg_width_p(MW),
      .paddr_width_p(AW), .hash_lsb_p(LSB)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .cmd_i(cmd_msg), .cmd_addr_i(cmd_addr), .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_ready),
      .resp_o(resp_d), .resp_v_o(resp_v), .resp_yumi_i(yumi),
      .chan_cmd_o(chan_cmd_d), .chan_cmd_v_o(chan_cmd_v), .chan_cmd_ready_and_i(chan_rdy),
      .chan_resp_i(crd), .chan_resp_v_i(crv), .chan_resp_yumi_o(cy),
      .idle_o(idle), .protocol_err_o(perr)
   );

   int n_cmp = 0, n_bad = 0;
   int n_acc_r = 0;
   bit started = 0, rnd = 0, merr = 0;
   int oq[$];                  // channel of each outstanding command, oldest first
   logic [MW-1:0] sb[$];       // upstream messages awaiting their response (random phase)
   logic [MW-1:0] chq[CH][$];  // per-channel pending responses (random phase)

   task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int tgt(input logic [AW-1:0] a);
      logic [AW-1:0] s;
      s = (a >> LSB) % CH;
      return int'(s);
   endfunction

   function automatic int mcnt(input int k);
      int n = 0;
      foreach (oq[i]) if (oq[i] == k) n++;
      return n;
   endfunction

   function automatic bit mroom(input int t);
      return (mcnt(t) < MAX) && (oq.size() < CH * MAX);
   endfunction

   function automatic bit mresp_v();
      return !rst && (oq.size() > 0) && crv[oq[0]];
   endfunction

   // Reference model: advances on each clock edge from the inputs alone.
   always @(posedge clk) begin
      int t, h;
      bit acc, pop;
      started = 1;
      if (rst) begin
         oq.delete(); sb.delete(); merr = 0;
         for (int k = 0; k < CH; k++) chq[k].delete();
      end else begin
         t   = tgt(cmd_addr);
         acc = cmd_v && chan_rdy[t] && mroom(t);
         pop = yumi && mresp_v();
         for (int k = 0; k < CH; k++) if (crv[k] && mcnt(k) == 0) merr = 1;
         if (pop) begin
            h = oq.pop_front();
            if (rnd) begin
               void'(chq[h].pop_front());
               void'(sb.pop_front());
            end
         end
         if (acc) begin
            oq.push_back(t);
            if (rnd) begin
               chq[t].push_back(cmd_msg);
               sb.push_back(cmd_msg);
               n_acc_r++;
            end
         end
      end
   end

   // Compare every output against the model once per cycle.
   always @(negedge clk) begin
      int t;
      bit rv;
      logic [CH-1:0] ecv, ey;
      if (started) begin
         t   = tgt(cmd_addr);
         ecv = '0;
         ey  = '0;
         if (!rst && cmd_v && mroom(t)) ecv[t] = 1'b1;
         if (!rst && oq.size() > 0 && yumi) ey[oq[0]] = 1'b1;
         rv = mresp_v();
         chk("cmd_ready", MW'(cmd_ready), MW'(!rst && chan_rdy[t] && mroom(t)));
         chk("chan_cmd_v", MW'(chan_cmd_v), MW'(ecv));
         for (int k = 0; k < CH; k++) chk("chan_cmd_o", chan_cmd_d[k], cmd_msg);
         chk("resp_v", MW'(resp_v), MW'(rv));
         if (rv) chk("resp_o_head", resp_d, crd[oq[0]]);
         chk("chan_resp_yumi", MW'(cy), MW'(ey));
         chk("idle", MW'(idle), MW'(rst || oq.size() == 0));
         chk("protocol_err", MW'(perr), MW'(merr));
         if (rnd && rv && yumi) begin
            if (sb.size() == 0) chk("order_nonempty", MW'(0), MW'(1));
            else chk("order", resp_d, sb[0] ^ K);
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && oq.size() > 0; i++) begin
         crv = '0;
         crv[oq[0]] = 1'b1;
         crd[oq[0]] = MW'(i);
         yumi = 1'b1;
         cyc();
      end
      crv = '0; yumi = 1'b0;
      look();
      chk("drain_idle", MW'(idle), MW'(1));
      cyc();
   endtask

   task automatic drive_rand_resp();
      for (int k = 0; k < CH; k++) begin
         if (chq[k].size() > 0 && ($urandom % 4) != 0) begin
            crv[k] = 1'b1;
            crd[k] = chq[k][0] ^ K;
         end else begin
            crv[k] = 1'b0;
            crd[k] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      yumi = mresp_v() && (($urandom % 4) != 0);
   endtask

   initial begin
      rst = 1; cmd_v = 1; cmd_addr = '0; cmd_msg = '0; chan_rdy = '1;
      crv = '1; crd = '0; yumi = 1;
      repeat (2) cyc();
      look();
      chk("rst_idle", MW'(idle), MW'(1));
      chk("rst_cmd_ready", MW'(cmd_ready), MW'(0));
      chk("rst_chan_cmd_v", MW'(chan_cmd_v), MW'(0));
      chk("rst_resp_v", MW'(resp_v), MW'(0));
      chk("rst_yumi", MW'(cy), MW'(0));
      chk("rst_err", MW'(perr), MW'(0));
      cyc();
      rst = 0; cmd_v = 0; crv = '0; yumi = 0;

      // Out-of-order channel responses come back in command order.
      cmd_v = 1; cmd_addr = 'h000; cmd_msg = M0;
      look();
      chk("a_ready", MW'(cmd_ready), MW'(1));
      chk("a_ccv0", MW'(chan_cmd_v), MW'(2'b01));
      cyc();
      cmd_addr = 'h040; cmd_msg = M1;
      look();
      chk("a_ccv1", MW'(chan_cmd_v), MW'(2'b10));
      chk("a_cmd1", chan_cmd_d[1], M1);
      cyc();
      cmd_v = 0; crv = 2'b10; crd[1] = R1;
      look();
      chk("a_hold_rv", MW'(resp_v), MW'(0));
      chk("a_hold_idle", MW'(idle), MW'(0));
      cyc();
      crd[0] = R0; crv = 2'b11; yumi = 1;
      look();
      chk("a_first_v", MW'(resp_v), MW'(1));
      chk("a_first", resp_d, R0);
      chk("a_first_yumi", MW'(cy), MW'(2'b01));
      cyc();
      crv = 2'b10;
      look();
      chk("a_second", resp_d, R1);
      chk("a_second_yumi", MW'(cy), MW'(2'b10));
      cyc();
      crv = '0; yumi = 0;
      look();
      chk("a_idle", MW'(idle), MW'(1));
      cyc();

      // Per-channel credit limit blocks ch0 only.
      cmd_v = 1; cmd_addr = 'h000;
      for (int i = 0; i < MAX; i++) begin
         cmd_msg = MW'(i);
         cyc();
      end
      look();
      chk("b_full_ready", MW'(cmd_ready), MW'(0));
      chk("b_full_ccv", MW'(chan_cmd_v), MW'(0));
      cyc();
      cmd_addr = 'h040;
      look();
      chk("b_ch1_ready", MW'(cmd_ready), MW'(1));
      chk("b_ch1_ccv", MW'(chan_cmd_v), MW'(2'b10));
      cyc();
      cmd_v = 0;
      drain();

      // Simultaneous push and pop on ch0 leaves its count unchanged.
      cmd_v = 1; cmd_addr = 'h000;
      repeat (3) cyc();
      crv = 2'b01; crd[0] = R0; yumi = 1;
      look();
      chk("c_ready", MW'(cmd_ready), MW'(1));
      chk("c_rv", MW'(resp_v), MW'(1));
      chk("c_yumi", MW'(cy), MW'(2'b01));
      cyc();
      crv = '0; yumi = 0; cmd_v = 0;
      look();
      chk("c_idle", MW'(idle), MW'(0));
      cmd_v = 1;
      repeat (5) cyc();
      look();
      chk("c_count3", MW'(cmd_ready), MW'(0));
      cmd_v = 0;
      cyc();
      drain();

      // Unsolicited response sets the sticky error and is not consumed.
      crv = 2'b10; crd[1] = R1;
      look();
      chk("d_yumi", MW'(cy), MW'(0));
      chk("d_rv", MW'(resp_v), MW'(0));
      chk("d_err_before", MW'(perr), MW'(0));
      cyc();
      crv = '0;
      look();
      chk("d_err_set", MW'(perr), MW'(1));
      repeat (4) cyc();
      look();
      chk("d_err_sticky", MW'(perr), MW'(1));
      cyc();

      // Reset mid-operation discards order state.
      cmd_v = 1;
      for (int i = 0; i < 5; i++) begin
         cmd_addr = (i % 2 == 1) ? AW'('h040) : AW'('h000);
         cyc();
      end
      cmd_v = 0; rst = 1; crv = 2'b11;
      look();
      chk("e_rst_idle", MW'(idle), MW'(1));
      chk("e_rst_rv", MW'(resp_v), MW'(0));
      cyc();
      rst = 0; crv = '0;
      look();
      chk("e_idle", MW'(idle), MW'(1));
      chk("e_rv", MW'(resp_v), MW'(0));
      chk("e_err_clr", MW'(perr), MW'(0));
      cmd_v = 1; cmd_addr = 'h000;
      repeat (MAX) cyc();
      look();
      chk("e_cnt_zero", MW'(cmd_ready), MW'(0));
      cmd_v = 0;
      cyc();
      drain();

      // Random stream with channel stalls; order checked on every pop.
      rnd = 1;
      for (int c = 0; c < 60000 && n_acc_r < 10000; c++) begin
         cmd_v    = ($urandom % 4) != 0;
         cmd_addr = AW'({$urandom, $urandom});
         cmd_msg  = {$urandom, $urandom, $urandom, $urandom};
         chan_rdy = CH'($urandom);
         drive_rand_resp();
         cyc();
      end
      cmd_v = 0;
      for (int c = 0; c < 4000 && oq.size() > 0; c++) begin
         drive_rand_resp();
         cyc();
      end
      crv = '0; yumi = 0;
      look();
      chk("r_accepted", MW'(n_acc_r), MW'(10000));
      chk("r_final_idle", MW'(idle), MW'(1));
      chk("r_no_leftover", MW'(sb.size()), MW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
